// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM state encoding and the
// grant identifier used by the round-robin picker and the top.
package riscv_mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} arb_state_t;
  typedef enum logic       {GNT_I, GNT_D}               arb_gnt_t;

endpackage

// File: rtl/riscv_mem_arb_rr.sv
// Two-way round-robin pick between the I-cache and D-cache requests.
// Ports:
//   req_i, req_d : requests from I-cache / D-cache
//   last_grant   : requester served by the previous transaction
//   gnt_vld      : at least one request present
//   gnt          : chosen requester (only meaningful when gnt_vld)
module riscv_mem_arb_rr
  import riscv_mem_arb_pkg::*;
(
  input  logic     req_i,
  input  logic     req_d,
  input  arb_gnt_t last_grant,
  output logic     gnt_vld,
  output arb_gnt_t gnt
);

  always_comb begin
    gnt_vld = req_i | req_d;
    gnt     = GNT_D;
    // On a tie the requester that did not win last time goes first.
    if (req_i && req_d) gnt = (last_grant == GNT_I) ? GNT_D : GNT_I;
    else if (req_i)     gnt = GNT_I;
  end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shares one memory port between the I-cache refill path and the D-cache
// refill/writeback path, one transaction at a time:
// IDLE -> BUSY_I | BUSY_D -> RESP -> IDLE.
// Ports:
//   clk, rst_n                   : clock, async active-low reset
//   i_req/i_addr                 : I-cache refill request
//   i_rdata/i_ready              : I-cache response (ready = one-cycle pulse)
//   d_req/d_we/d_addr/d_wdata    : D-cache refill (we=0) or writeback (we=1)
//   d_rdata/d_ready              : D-cache response (ready = one-cycle pulse)
//   mem_rden/mem_wren/mem_addr/mem_wdata : memory command, held until mem_ready
//   mem_rdata/mem_ready          : memory completion
//   err_timeout                  : sticky, a transaction waited TIMEOUT cycles
module riscv_mem_arbiter
  import riscv_mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 23,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [S_ADDR-1:0]     i_addr,
  output logic [DATA_WIDTH-1:0] i_rdata,
  output logic                  i_ready,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [S_ADDR-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_ready,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [S_ADDR-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  arb_state_t            state_q;
  arb_gnt_t              last_gnt_q;
  arb_gnt_t              gnt;
  logic                  gnt_vld;
  logic                  rden_q, wren_q;
  logic [S_ADDR-1:0]     addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, i_rdata_q, d_rdata_q;
  logic                  i_ready_q, d_ready_q;
  logic [CW-1:0]         cnt_q;
  logic                  err_q;

  riscv_mem_arb_rr u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_grant (last_gnt_q),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= GNT_D;  // so I-cache wins the first tie
      rden_q     <= 1'b0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_ready_q  <= 1'b0;
      d_ready_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            last_gnt_q <= gnt;
            cnt_q      <= '0;
            if (gnt == GNT_I) begin
              rden_q  <= 1'b1;
              wren_q  <= 1'b0;
              addr_q  <= i_addr;
              state_q <= BUSY_I;
            end else begin
              rden_q  <= ~d_we;
              wren_q  <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              state_q <= BUSY_D;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            rden_q  <= 1'b0;
            wren_q  <= 1'b0;
            state_q <= RESP;
            if (state_q == BUSY_I) begin
              i_rdata_q <= mem_rdata;
              i_ready_q <= 1'b1;
            end else begin
              // Writebacks leave the previous refill data in place.
              if (rden_q) d_rdata_q <= mem_rdata;
              d_ready_q <= 1'b1;
            end
          end else begin
            // No abort on timeout: flag it and keep waiting.
            if (cnt_q != TO_MAX)       cnt_q <= cnt_q + 1'b1;
            if (cnt_q == TO_MAX - 1'b1) err_q <= 1'b1;
          end
        end
        RESP: begin
          i_ready_q <= 1'b0;
          d_ready_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rden    = rden_q;
  assign mem_wren    = wren_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign i_ready     = i_ready_q;
  assign d_ready     = d_ready_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
module tb_riscv_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic          i_ready, d_ready, mem_rden, mem_wren, err_timeout;
  logic [AW-1:0] mem_addr;

  riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct { logic is_i; logic [DW-1:0] data; } exp_t;
  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the grant edge: checks the command is held for n
  // cycles, completes it with rd on the n-th edge.
  task automatic serve(input int n, input logic [DW-1:0] rd, input logic rd_en,
                       input logic wr_en, input logic [AW-1:0] a);
    for (int k = 0; k < n; k++) begin
      check("en_held", {mem_rden, mem_wren}, {rd_en, wr_en});
      check("addr_held", mem_addr, a);
      if (k == n - 1) begin
        mem_ready = 1'b1;
        mem_rdata = rd;
      end
      tick();
    end
    mem_ready = 1'b0;
    mem_rdata = '0;
    check("en_drop", {mem_rden, mem_wren}, 2'b00);
  endtask

  // Monitor: every ready pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (i_ready || d_ready)) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_ready: got i=%0b d=%0b expected none", i_ready, d_ready);
      end else begin
        e = sb.pop_front();
        check("resp_who", {i_ready, d_ready}, {e.is_i, ~e.is_i});
        check("resp_data", e.is_i ? i_rdata : d_rdata, e.data);
      end
    end
  end

  localparam logic [DW-1:0] A5 = {16{8'hA5}};
  localparam logic [DW-1:0] D1 = 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444;
  localparam logic [DW-1:0] DR = 128'hDEAD_BEEF_0000_0001_0000_0002_0000_0003;
  localparam logic [DW-1:0] JK = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
  localparam logic [DW-1:0] DA = 128'hAAAA_0001;
  localparam logic [DW-1:0] DB = 128'hBBBB_0002;
  localparam logic [DW-1:0] DC = 128'hCCCC_0003;
  localparam logic [DW-1:0] DE = 128'hEEEE_0004;
  localparam logic [DW-1:0] DF = 128'hFFFF_0005;

  initial begin
    rst_n = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    check("rst_en", {mem_rden, mem_wren}, 2'b00);
    check("rst_ready", {i_ready, d_ready}, 2'b00);
    check("rst_addr", mem_addr, '0);
    check("rst_rdata", i_rdata | d_rdata | mem_wdata, '0);
    check("rst_err", err_timeout, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: I only, memory answers after 3 cycles
    i_req = 1; i_addr = 23'h10;
    sb.push_back('{1'b1, D1});
    tick();
    check("t1_gnt_rden", mem_rden, 1'b1);
    serve(3, D1, 1'b1, 1'b0, 23'h10);
    i_req = 0;
    tick();
    check("t1_idle_ready", {i_ready, d_ready}, 2'b00);

    // 2: D refill, then D writeback must leave d_rdata untouched
    d_req = 1; d_we = 0; d_addr = 23'h21;
    sb.push_back('{1'b0, DR});
    tick();
    serve(2, DR, 1'b1, 1'b0, 23'h21);
    d_req = 0;
    tick();
    d_req = 1; d_we = 1; d_addr = 23'h22; d_wdata = A5;
    sb.push_back('{1'b0, DR});
    tick();
    check("t2_wdata", mem_wdata, A5);
    serve(2, JK, 1'b0, 1'b1, 23'h22);
    d_req = 0; d_we = 0;
    tick();

    // 3: ties from reset alternate I, D, I
    rst_n = 0;
    #1;
    check("t3_rst_rdata", d_rdata, '0);
    tick();
    rst_n = 1;
    i_req = 1; i_addr = 23'h31; d_req = 1; d_addr = 23'h42;
    sb.push_back('{1'b1, DA});
    tick();
    serve(1, DA, 1'b1, 1'b0, 23'h31);
    sb.push_back('{1'b0, DB});
    tick();
    check("t3_idle_gap", mem_rden, 1'b0);
    tick();
    serve(1, DB, 1'b1, 1'b0, 23'h42);
    sb.push_back('{1'b1, DC});
    tick();
    tick();
    serve(1, DC, 1'b1, 1'b0, 23'h31);
    i_req = 0; d_req = 0;
    tick();

    // 4: timeout after 8 waiting cycles, then normal completion
    i_req = 1; i_addr = 23'h55;
    sb.push_back('{1'b1, DE});
    tick();
    for (int k = 0; k < 7; k++) tick();
    check("t4_err_before", err_timeout, 1'b0);
    tick();
    check("t4_err_set", err_timeout, 1'b1);
    tick();
    tick();
    serve(1, DE, 1'b1, 1'b0, 23'h55);
    i_req = 0;
    tick();
    check("t4_err_sticky", err_timeout, 1'b1);

    // 5: reset during a D writeback
    d_req = 1; d_we = 1; d_addr = 23'h66; d_wdata = A5;
    tick();
    check("t5_wren", mem_wren, 1'b1);
    tick();
    rst_n = 0;
    #1;
    check("t5_async_drop", {mem_rden, mem_wren}, 2'b00);
    check("t5_err_clr", err_timeout, 1'b0);
    d_req = 0; d_we = 0;
    tick();
    rst_n = 1;
    i_req = 1; i_addr = 23'h31; d_req = 1; d_addr = 23'h42;
    sb.push_back('{1'b1, DF});
    tick();
    check("t5_tie_gnt_i", mem_addr, 23'h31);
    serve(1, DF, 1'b1, 1'b0, 23'h31);
    i_req = 0; d_req = 0;
    tick();

    // 6: stray mem_ready while idle
    mem_ready = 1; mem_rdata = JK;
    tick();
    mem_ready = 0; mem_rdata = '0;
    check("t6_no_en", {mem_rden, mem_wren}, 2'b00);
    check("t6_no_ready", {i_ready, d_ready}, 2'b00);
    tick();
    check("t6_still_idle", {i_ready, d_ready, mem_rden}, 3'b000);
    check("t6_rdata_kept", i_rdata, DF);

    tick();
    check("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
